// File: rtl/inst_fetch.sv
// +----------------------------------------------------------------------------+
// | inst_fetch: single-outstanding instruction fetch stage with redirect/squash |
// | Optional macro IFU_FAULT_EN adds fetch_fault and misaligned/err fault hold.  |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module inst_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_FAULT_EN
  ,
  output logic            fetch_fault
`endif
);

`ifdef IFU_FAULT_EN
  localparam logic FAULT_EN = 1'b1;
`else
  localparam logic FAULT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic            pend_fault_q;
  logic            req_valid_q;
  logic            inst_valid_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            fault_q;

  logic            w_mis;
  logic [XLEN-1:0] w_rpc;
  logic            w_err;
  logic            w_redir_now;
  logic            w_redir_defer;

  assign w_mis = FAULT_EN & (redirect_pc[1:0] != 2'b00);
  assign w_rpc = FAULT_EN ? redirect_pc : {redirect_pc[XLEN-1:2], 2'b00};
  assign w_err = FAULT_EN & imem_resp_err;

  // A redirect either takes effect at once, or must wait for the already
  // accepted request's response to drain (drop it when it arrives).
  assign w_redir_now = redirect_valid &&
                       (((state_q == S_REQ)  && !imem_req_ready)  ||
                        ((state_q == S_WAIT) &&  imem_resp_valid) ||
                         (state_q == S_HOLD) || (state_q == S_FAULT));
  assign w_redir_defer = redirect_valid &&
                         (((state_q == S_REQ)  &&  imem_req_ready) ||
                          ((state_q == S_WAIT) && !imem_resp_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      pend_fault_q <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fault_q      <= 1'b0;
    end else if (w_redir_now) begin
      pc_q         <= w_rpc;
      drop_q       <= 1'b0;
      pend_fault_q <= 1'b0;
      if (w_mis) begin
        state_q      <= S_HOLD;
        req_valid_q  <= 1'b0;
        inst_valid_q <= 1'b1;
        inst_q       <= '0;
        inst_pc_q    <= redirect_pc;
        fault_q      <= 1'b1;
      end else begin
        state_q      <= S_REQ;
        req_valid_q  <= 1'b1;
        inst_valid_q <= 1'b0;
        fault_q      <= 1'b0;
      end
    end else if (w_redir_defer) begin
      pc_q         <= w_rpc;
      drop_q       <= 1'b1;
      pend_fault_q <= w_mis;
      state_q      <= S_WAIT;
      req_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q     <= S_REQ;
          req_valid_q <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              drop_q       <= 1'b0;
              pend_fault_q <= 1'b0;
              if (pend_fault_q) begin
                state_q      <= S_HOLD;
                inst_valid_q <= 1'b1;
                inst_q       <= '0;
                inst_pc_q    <= pc_q;
                fault_q      <= 1'b1;
              end else begin
                state_q     <= S_REQ;
                req_valid_q <= 1'b1;
              end
            end else begin
              state_q      <= S_HOLD;
              inst_valid_q <= 1'b1;
              inst_q       <= w_err ? '0 : imem_resp_data;
              inst_pc_q    <= pc_q;
              fault_q      <= w_err;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            if (fault_q) begin
              state_q <= S_FAULT;
            end else begin
              pc_q        <= pc_q + XLEN'(4);
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q     <= S_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
`ifdef IFU_FAULT_EN
  assign fetch_fault    = fault_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch; fault cases built with IFU_FAULT_EN.
`default_nettype none

module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_FAULT_EN
  logic        fetch_fault;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef IFU_FAULT_EN
    ,
    .fetch_fault     (fetch_fault)
`endif
  );

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rd;
    logic        ir, redv;
    logic [31:0] rpc;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                              input logic [31:0] rd, input logic ir,
                              input logic redv, input logic [31:0] rpc,
                              input logic e_rqv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_inst,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.redv = redv;
    v.rpc = rpc; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic rerr, input logic ir,
                       input logic redv, input logic [31:0] rpc);
    rst = r; imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
    imem_resp_err = rerr; inst_ready = ir; redirect_valid = redv; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_rqv, input logic [31:0] e_addr,
                         input logic e_iv, input logic [31:0] e_inst,
                         input logic [31:0] e_ipc);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rqv});
    chk({tag, ".req_addr"}, imem_req_addr, e_addr);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_iv});
    if (e_iv) begin
      chk({tag, ".inst"}, inst, e_inst);
      chk({tag, ".inst_pc"}, inst_pc, e_ipc);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // Reset and straight-line fetch (memory returns ~addr)
    tbl.push_back(mk(1,0,0,0,0,0,0,                     0,32'h80000000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,                     1,32'h80000000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80000000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h7FFFFFFF,1,0,0,          0,32'h80000000,1,32'h7FFFFFFF,32'h80000000));
    tbl.push_back(mk(0,0,0,0,1,0,0,                     1,32'h80000004,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80000004,0,0,0));
    tbl.push_back(mk(0,0,1,32'h7FFFFFFB,0,0,0,          0,32'h80000004,1,32'h7FFFFFFB,32'h80000004));
    tbl.push_back(mk(0,0,0,0,1,0,0,                     1,32'h80000008,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80000008,0,0,0));
    tbl.push_back(mk(0,0,1,32'h7FFFFFF7,0,0,0,          0,32'h80000008,1,32'h7FFFFFF7,32'h80000008));
    // Consumer stall for 5 cycles: buffer stable, no request
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,0,0,0,0,0,                   0,32'h80000008,1,32'h7FFFFFF7,32'h80000008));
    tbl.push_back(mk(0,0,0,0,1,0,0,                     1,32'h8000000C,0,0,0));
    // Redirect while waiting: DEADBEEF must be discarded
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h8000000C,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h80001000,          0,32'h80001000,0,0,0));
    tbl.push_back(mk(0,0,1,32'hDEADBEEF,0,0,0,          1,32'h80001000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80001000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h7FFFEFFF,0,0,0,          0,32'h80001000,1,32'h7FFFEFFF,32'h80001000));
    tbl.push_back(mk(0,0,0,0,1,0,0,                     1,32'h80001004,0,0,0));
    // Redirect in the same cycle the request is accepted
    tbl.push_back(mk(0,1,0,0,0,1,32'h80002000,          0,32'h80002000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h12345678,0,0,0,          1,32'h80002000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80002000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h7FFFDFFF,0,0,0,          0,32'h80002000,1,32'h7FFFDFFF,32'h80002000));
    // Redirect together with inst_ready in HOLD
    tbl.push_back(mk(0,0,0,0,1,1,32'h80003000,          1,32'h80003000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80003000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h7FFFCFFF,0,0,0,          0,32'h80003000,1,32'h7FFFCFFF,32'h80003000));
    // Redirect in HOLD without consume, then in REQ while unaccepted
    tbl.push_back(mk(0,0,0,0,0,1,32'h80004000,          1,32'h80004000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h80005000,          1,32'h80005000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80005000,0,0,0));
    // Redirect coincident with the response: response discarded
    tbl.push_back(mk(0,0,1,32'hBADBAD00,0,1,32'h80006000,1,32'h80006000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80006000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h7FFF9FFF,0,0,0,          0,32'h80006000,1,32'h7FFF9FFF,32'h80006000));
    tbl.push_back(mk(0,0,0,0,1,0,0,                     1,32'h80006004,0,0,0));
    // PC wrap at top of address space
    tbl.push_back(mk(0,0,0,0,0,1,32'hFFFFFFFC,          1,32'hFFFFFFFC,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'hFFFFFFFC,0,0,0));
    tbl.push_back(mk(0,0,1,32'h00000003,0,0,0,          0,32'hFFFFFFFC,1,32'h00000003,32'hFFFFFFFC));
    tbl.push_back(mk(0,0,0,0,1,0,0,                     1,32'h00000000,0,0,0));
    // Reset mid-operation; stale responses in IDLE/REQ ignored
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h00000000,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,                     0,32'h80000000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h11111111,0,0,0,          1,32'h80000000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h22222222,0,0,0,          1,32'h80000000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,                     0,32'h80000000,0,0,0));
    tbl.push_back(mk(0,0,1,32'h7FFFFFFF,0,0,0,          0,32'h80000000,1,32'h7FFFFFFF,32'h80000000));

    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    imem_resp_err = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rd, 1'b0, tbl[i].ir,
            tbl[i].redv, tbl[i].rpc);
      chk_out($sformatf("v%0d", i), tbl[i].e_rqv, tbl[i].e_addr, tbl[i].e_iv,
              tbl[i].e_inst, tbl[i].e_ipc);
    end

`ifdef IFU_FAULT_EN
    // Response error: fault hold, then parked until a redirect
    drive(0,0,0,0,0,1,0,0);              chk_out("f0", 1, 32'h80000004, 0, 0, 0);
    drive(0,1,0,0,0,0,0,0);              chk_out("f1", 0, 32'h80000004, 0, 0, 0);
    drive(0,0,1,32'hCAFEF00D,1,0,0,0);   chk_out("f2", 0, 32'h80000004, 1, 0, 32'h80000004);
    chk("f2.fault", {31'd0, fetch_fault}, 32'd1);
    drive(0,0,0,0,0,0,0,0);              chk_out("f3", 0, 32'h80000004, 1, 0, 32'h80000004);
    chk("f3.fault", {31'd0, fetch_fault}, 32'd1);
    drive(0,1,0,0,0,1,0,0);              chk_out("f4", 0, 32'h80000004, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0,1,0,0,0,0,0,0);            chk_out($sformatf("f5_%0d", i), 0, 32'h80000004, 0, 0, 0);
    end
    drive(0,0,0,0,0,0,1,32'h80000100);   chk_out("f6", 1, 32'h80000100, 0, 0, 0);
    chk("f6.fault", {31'd0, fetch_fault}, 32'd0);
    drive(0,1,0,0,0,0,0,0);              chk_out("f7", 0, 32'h80000100, 0, 0, 0);
    drive(0,0,1,32'h7FFFFEFF,0,0,0,0);   chk_out("f8", 0, 32'h80000100, 1, 32'h7FFFFEFF, 32'h80000100);
    chk("f8.fault", {31'd0, fetch_fault}, 32'd0);
    // Misaligned redirect: fault without any memory request
    drive(0,0,0,0,0,0,1,32'h80000202);   chk_out("f9", 0, 32'h80000202, 1, 0, 32'h80000202);
    chk("f9.fault", {31'd0, fetch_fault}, 32'd1);
    drive(0,1,0,0,0,1,0,0);              chk_out("f10", 0, 32'h80000202, 0, 0, 0);
    drive(0,0,0,0,0,0,1,32'h80000300);   chk_out("f11", 1, 32'h80000300, 0, 0, 0);
    chk("f11.fault", {31'd0, fetch_fault}, 32'd0);
`else
    // Misaligned redirect masked; response error ignored
    drive(0,0,0,0,0,0,1,32'h80007003);   chk_out("m0", 1, 32'h80007000, 0, 0, 0);
    drive(0,1,0,0,0,0,0,0);              chk_out("m1", 0, 32'h80007000, 0, 0, 0);
    drive(0,0,1,32'hCAFEF00D,1,0,0,0);   chk_out("m2", 0, 32'h80007000, 1, 32'hCAFEF00D, 32'h80007000);
    drive(0,0,0,0,0,1,0,0);              chk_out("m3", 1, 32'h80007004, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
